// File: rtl/pipeline_pkg.sv
// Shared pipeline types: load funct3 encodings and the default-width writeback entry layout.
package pipeline_pkg;

  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_ADDR_WIDTH = 32;
  localparam int unsigned WB_REG_W      = 5;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] pc;
    logic [WB_REG_W-1:0]      rd;
    logic                     we;
    logic [WB_DATA_WIDTH-1:0] data;
  } writeback_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load-result formatter: picks the byte/half lane from a raw memory word and
// sign- or zero-extends it. Non-loads and unknown funct3 values pass through unchanged.
module load_formatter
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] raw_i,
  input  logic                  is_load_i,
  input  logic [2:0]            funct3_i,
  input  logic [1:0]            byte_offset_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lanes are taken from the low 32-bit word regardless of DATA_WIDTH.
  assign byte_sel = raw_i[{byte_offset_i, 3'b000} +: 8];
  assign half_sel = raw_i[{byte_offset_i[1], 4'b0000} +: 16];

  always_comb begin
    data_o = raw_i;
    if (is_load_i) begin
      case (load_funct3_e'(funct3_i))
        LB:      data_o = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
        LBU:     data_o = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
        LH:      data_o = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
        LHU:     data_o = {{(DATA_WIDTH-16){1'b0}}, half_sel};
        default: data_o = raw_i;
      endcase
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// In-order writeback retire queue with load formatting at push, x0 write suppression and a
// 64-bit retired counter. Define WRITEBACK_BYPASS_EN to add the youngest-match bypass lookup.
module writeback_queue
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned NUM_REGISTERS = 32,
  parameter int unsigned DEPTH         = 2,
  localparam int unsigned REG_W        = $clog2(NUM_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prev_done,
  output logic                  stall_prev,
  output logic                  done_next,
  input  logic                  next_stall,
  input  logic [ADDR_WIDTH-1:0] program_count_in,
  input  logic                  is_load_in,
  input  logic [2:0]            load_funct3_in,
  input  logic [1:0]            byte_offset_in,
  input  logic [REG_W-1:0]      write_register_in,
  input  logic                  write_register_valid_in,
  input  logic [DATA_WIDTH-1:0] result_data_in,
  output logic [ADDR_WIDTH-1:0] program_count_out,
  output logic [REG_W-1:0]      write_register,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_activate,
`ifdef WRITEBACK_BYPASS_EN
  input  logic [REG_W-1:0]      bypass_register,
  output logic                  bypass_hit,
  output logic [DATA_WIDTH-1:0] bypass_data,
`endif
  output logic [63:0]           retired_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [REG_W-1:0]      rd;
    logic                  we;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t                mem_q [DEPTH];
  entry_t                new_entry;
  entry_t                head;
  logic [DATA_WIDTH-1:0] fmt_data;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [63:0]           retired_q, retired_d;
  logic                  full, empty, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  load_formatter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_formatter (
    .raw_i        (result_data_in),
    .is_load_i    (is_load_in),
    .funct3_i     (load_funct3_in),
    .byte_offset_i(byte_offset_in),
    .data_o       (fmt_data)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A full queue still accepts when the head leaves in the same cycle.
  assign done_next  = !rst && !empty;
  assign pop        = done_next && !next_stall;
  assign stall_prev = rst || (full && !pop);
  assign push       = prev_done && !stall_prev;

  always_comb begin
    new_entry      = '0;
    new_entry.pc   = program_count_in;
    new_entry.rd   = write_register_in;
    new_entry.we   = write_register_valid_in && (write_register_in != '0);
    new_entry.data = fmt_data;
  end

  assign head              = mem_q[rd_ptr_q];
  assign program_count_out = head.pc;
  assign write_register    = head.rd;
  assign write_data        = head.data;
  assign write_activate    = pop && head.we;
  assign retired_count     = retired_q;

  always_comb begin
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    retired_d = pop  ? retired_q + 64'd1 : retired_q;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      retired_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      retired_q <= retired_d;
    end
  end

  // Entry storage is deliberately not reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

`ifdef WRITEBACK_BYPASS_EN
  logic [PTR_W-1:0] scan_idx;

  // Walk oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    bypass_hit  = 1'b0;
    bypass_data = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = PTR_W'((32'(rd_ptr_q) + i) % DEPTH);
      if ((i < 32'(count_q)) && mem_q[scan_idx].we &&
          (mem_q[scan_idx].rd == bypass_register)) begin
        bypass_hit  = 1'b1;
        bypass_data = mem_q[scan_idx].data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: scoreboard of expected retirements checked at each pop.
module tb_writeback_queue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prev_done = 1'b0;
  logic        stall_prev;
  logic        done_next;
  logic        next_stall = 1'b0;
  logic [31:0] program_count_in = '0;
  logic        is_load_in = 1'b0;
  logic [2:0]  load_funct3_in = '0;
  logic [1:0]  byte_offset_in = '0;
  logic [4:0]  write_register_in = '0;
  logic        write_register_valid_in = 1'b0;
  logic [31:0] result_data_in = '0;
  logic [31:0] program_count_out;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        write_activate;
  logic [63:0] retired_count;
`ifdef WRITEBACK_BYPASS_EN
  logic [4:0]  bypass_register = '0;
  logic        bypass_hit;
  logic [31:0] bypass_data;
`endif

  always #5 clk = ~clk;

  writeback_queue #(
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .NUM_REGISTERS(32),
    .DEPTH        (DEPTH)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .prev_done              (prev_done),
    .stall_prev             (stall_prev),
    .done_next              (done_next),
    .next_stall             (next_stall),
    .program_count_in       (program_count_in),
    .is_load_in             (is_load_in),
    .load_funct3_in         (load_funct3_in),
    .byte_offset_in         (byte_offset_in),
    .write_register_in      (write_register_in),
    .write_register_valid_in(write_register_valid_in),
    .result_data_in         (result_data_in),
    .program_count_out      (program_count_out),
    .write_register         (write_register),
    .write_data             (write_data),
    .write_activate         (write_activate),
`ifdef WRITEBACK_BYPASS_EN
    .bypass_register        (bypass_register),
    .bypass_hit             (bypass_hit),
    .bypass_data            (bypass_data),
`endif
    .retired_count          (retired_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend;
  logic [63:0] retired_exp = '0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] pc, input logic ld, input logic [2:0] f3,
                       input logic [1:0] off, input logic [4:0] rd, input logic v,
                       input logic [31:0] raw, input logic [31:0] expd);
    prev_done               = 1'b1;
    program_count_in        = pc;
    is_load_in              = ld;
    load_funct3_in          = f3;
    byte_offset_in          = off;
    write_register_in       = rd;
    write_register_valid_in = v;
    result_data_in          = raw;
    pend.pc   = pc;
    pend.rd   = rd;
    pend.we   = v && (rd != 5'd0);
    pend.data = expd;
  endtask

  // One clock cycle: check handshake/head at negedge, update model, check counter after edge.
  task automatic step();
    exp_t e;
    bit   exp_done, exp_pop, exp_stall, exp_push;
    @(negedge clk);
    exp_done  = (sb.size() != 0);
    exp_pop   = exp_done && !next_stall;
    exp_stall = (sb.size() == DEPTH) && !exp_pop;
    exp_push  = prev_done && !exp_stall;
    chk("done_next", done_next, exp_done);
    chk("stall_prev", stall_prev, exp_stall);
    if (exp_pop) begin
      e = sb.pop_front();
      chk("pc_out", program_count_out, e.pc);
      chk("write_register", write_register, e.rd);
      chk("write_data", write_data, e.data);
      chk("write_activate", write_activate, e.we);
    end else begin
      chk("write_activate_idle", write_activate, 1'b0);
    end
    if (exp_push) sb.push_back(pend);
    @(posedge clk);
    if (exp_pop) retired_exp = retired_exp + 64'd1;
    #1;
    chk("retired_count", retired_count, retired_exp);
  endtask

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_stall_prev", stall_prev, 1'b1);
    chk("rst_done_next", done_next, 1'b0);
    chk("rst_write_activate", write_activate, 1'b0);
    chk("rst_retired", retired_count, 64'd0);
`ifdef WRITEBACK_BYPASS_EN
    chk("rst_bypass_hit", bypass_hit, 1'b0);
`endif
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Single ALU op.
    offer(32'h100, 1'b0, 3'b000, 2'd0, 5'd5, 1'b1, 32'h1234_5678, 32'h1234_5678);
    step();
    prev_done = 1'b0;
    step();

    // Back-to-back loads, pass-through cases and an x0 write.
    offer(32'h104, 1'b1, 3'b000, 2'd3, 5'd6, 1'b1, 32'h80FF_FFFF, 32'hFFFF_FF80); step();
    offer(32'h108, 1'b1, 3'b100, 2'd3, 5'd7, 1'b1, 32'h80FF_FFFF, 32'h0000_0080); step();
    offer(32'h10C, 1'b1, 3'b001, 2'd2, 5'd8, 1'b1, 32'h8001_0000, 32'hFFFF_8001); step();
    offer(32'h110, 1'b1, 3'b101, 2'd2, 5'd9, 1'b1, 32'h8001_0000, 32'h0000_8001); step();
    offer(32'h114, 1'b1, 3'b010, 2'd1, 5'd10, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF); step();
    offer(32'h118, 1'b1, 3'b011, 2'd1, 5'd11, 1'b1, 32'h1122_3344, 32'h1122_3344); step();
    offer(32'h11C, 1'b1, 3'b000, 2'd1, 5'd12, 1'b1, 32'h0000_7F00, 32'h0000_007F); step();
    offer(32'h120, 1'b0, 3'b000, 2'd0, 5'd0, 1'b1, 32'h0000_0055, 32'h0000_0055); step();
    offer(32'h124, 1'b0, 3'b000, 2'd0, 5'd13, 1'b0, 32'h0000_0066, 32'h0000_0066); step();
    prev_done = 1'b0;
    step();
    step();

    // Fill under next_stall, hold a third, then push and pop together while full.
    next_stall = 1'b1;
    offer(32'h200, 1'b0, 3'b000, 2'd0, 5'd1, 1'b1, 32'hA000_0001, 32'hA000_0001); step();
    offer(32'h204, 1'b0, 3'b000, 2'd0, 5'd2, 1'b1, 32'hA000_0002, 32'hA000_0002); step();
    offer(32'h208, 1'b0, 3'b000, 2'd0, 5'd3, 1'b1, 32'hA000_0003, 32'hA000_0003); step();
    step();
    next_stall = 1'b0;
    step();
    offer(32'h20C, 1'b0, 3'b000, 2'd0, 5'd4, 1'b1, 32'hA000_0004, 32'hA000_0004); step();
    offer(32'h210, 1'b0, 3'b000, 2'd0, 5'd5, 1'b1, 32'hA000_0005, 32'hA000_0005); step();
    prev_done = 1'b0;
    step();
    step();
    step();

    // Two queued writes to r7, then asynchronous reset mid-cycle.
    next_stall = 1'b1;
    offer(32'h300, 1'b0, 3'b000, 2'd0, 5'd7, 1'b1, 32'h0000_000A, 32'h0000_000A); step();
    offer(32'h304, 1'b0, 3'b000, 2'd0, 5'd7, 1'b1, 32'h0000_000B, 32'h0000_000B); step();
    prev_done = 1'b0;
`ifdef WRITEBACK_BYPASS_EN
    bypass_register = 5'd7; #1;
    chk("bypass_hit_r7", bypass_hit, 1'b1);
    chk("bypass_data_r7", bypass_data, 32'h0000_000B);
    bypass_register = 5'd3; #1;
    chk("bypass_hit_r3", bypass_hit, 1'b0);
    bypass_register = 5'd0; #1;
    chk("bypass_hit_x0", bypass_hit, 1'b0);
    bypass_register = 5'd7;
`endif
    #1;
    rst        = 1'b1;
    next_stall = 1'b0;
    #1;
    chk("arst_done_next", done_next, 1'b0);
    chk("arst_stall_prev", stall_prev, 1'b1);
    chk("arst_write_activate", write_activate, 1'b0);
    chk("arst_retired", retired_count, 64'd0);
`ifdef WRITEBACK_BYPASS_EN
    chk("arst_bypass_hit", bypass_hit, 1'b0);
`endif
    sb.delete();
    retired_exp = '0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    step();

    // Queue works again after reset.
    offer(32'h400, 1'b0, 3'b000, 2'd0, 5'd31, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D); step();
    prev_done = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Parametrised writeback stage with a DEPTH-entry in-order retire queue between the memory stage and the commit/PC-update consumer. It formats load results (byte/half/word, signed/unsigned) from raw memory words, issues exactly one register-file write per retired instruction, and suppresses writes to x0. It also keeps a retired-instruction counter.

## Interface
- DATA_WIDTH, 32, register/result width (multiple of 8, ≥32)
- ADDR_WIDTH, 32, program-counter width
- NUM_REGISTERS, 32, architectural registers; REG_W = $clog2(NUM_REGISTERS)
- DEPTH, 2, queue entries (≥1, power of two)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- prev_done  in  1  upstream offers an instruction
- stall_prev  out  1  upstream must hold
- done_next  out  1  head entry offered downstream
- next_stall  in  1  downstream refuses head
- program_count_in  in  ADDR_WIDTH  instruction PC
- is_load_in  in  1  result is raw memory word needing formatting
- load_funct3_in  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- byte_offset_in  in  2  effective-address low bits
- write_register_in  in  REG_W  rd
- write_register_valid_in  in  1  instruction writes rd
- result_data_in  in  DATA_WIDTH  ALU result or raw load word
- program_count_out  out  ADDR_WIDTH  head PC
- write_register  out  REG_W  regfile index
- write_data  out  DATA_WIDTH  formatted result
- write_activate  out  1  regfile write strobe
- retired_count  out  64  instructions retired since reset
- bypass_register  in  REG_W  (bypass only) lookup index
- bypass_hit  out  1  (bypass only) a queued entry writes bypass_register
- bypass_data  out  DATA_WIDTH  (bypass only) youngest matching formatted value

## Operation
- push = prev_done && !stall_prev; pop = done_next && !next_stall.
- Load formatting happens at push; queue stores formatted data, rd, write-enable, PC.
- LB/LBU select byte byte_offset_in, LH/LHU select half byte_offset_in[1]; sign- or zero-extend to DATA_WIDTH. LW passes through. Other funct3 values: pass through unchanged. Non-loads pass through.
- write enable stored = write_register_valid_in && write_register_in != 0.
- write_activate = pop && head write enable; write_register/write_data always show head.
- retired_count increments by 1 on every pop, wraps at 2^64.
- stall_prev = rst || (full && !pop): push into a full queue is allowed in the same cycle as a pop.
- done_next = !rst && !empty.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
- Async reset: pointers, count, retired_count cleared immediately; entry contents not reset. Reset mid-operation discards all queued entries without writing them.

## Timing
- Reset values: stall_prev 1, done_next 0, write_activate 0, retired_count 0, bypass_hit 0; data outputs don't-care.
- Latency: entry pushed at edge N is head after N if queue was empty; earliest write_activate is in cycle N+1 (combinational from head and next_stall).
- Throughput: one push and one pop per cycle sustained with DEPTH ≥ 1.
- write_activate is combinational on next_stall; the regfile samples it on the following edge.

## Configuration
- WRITEBACK_BYPASS_EN defined: bypass_register/bypass_hit/bypass_data ports exist; combinational search over all valid entries with write enable; youngest match (closest to tail) wins; x0 never hits.
- Undefined: bypass ports absent; no search logic.

## Structure
- Shared package pipeline_pkg: load_funct3_e enum (LB, LH, LW, LBU, LHU), writeback_entry_t struct (pc, rd, we, data).
- Sub-module load_formatter: purely combinational raw word + funct3 + offset → formatted data; reused by future memory stage.

## Test plan
- Reset then single ALU op rd=5, data 0x1234_5678, next_stall=0 → write_activate one cycle later with rd 5, data 0x1234_5678; retired_count 1.
- LB offset 3, raw 0x80FF_FFFF → write_data 0xFFFF_FF80; LBU same → 0x0000_0080; LH offset 2, raw 0x8001_0000 → 0xFFFF_8001.
- rd=0 with valid write → pop occurs, write_activate 0, retired_count increments.
- next_stall held high, push DEPTH+1 instructions → stall_prev rises after DEPTH pushes; release → in-order writes, no loss/duplication.
- Full queue, push and pop same cycle → stall_prev 0, count stays DEPTH, PCs retire in order.
- Assert rst asynchronously with 2 entries queued → done_next drops immediately, no write_activate, retired_count 0; with WRITEBACK_BYPASS_EN, two queued writes to r7 (0xA, 0xB) → bypass_data 0xB.
